// File: rtl/mips_cpu_bus_sequencer.sv
// Multicycle control sequencer for the bus-interface MIPS CPU: owns the state register,
// drives the memory bus handshake and emits per-state strobes to the datapath.
module mips_cpu_bus_sequencer #(
  parameter int MD_LAT      = 32,
  parameter int WAIT_MAX    = 255,
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] function_code,
  input  logic [1:0] byte_addressing,
  input  logic       waitrequest,
  input  logic       halt_req,
  output logic [2:0] state,
  output logic       read,
  output logic       write,
  output logic [3:0] byteenable,
  output logic [2:0] write_data_sel,
  output logic       ir_load,
  output logic       exec_en,
  output logic       pc_en,
  output logic       load_wb,
  output logic       md_busy,
  output logic       active,
  output logic       fault
);

  localparam int MD_W = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;
  localparam int WD_W = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_IR_LATCH  = 3'd1,
    S_MEM       = 3'd2,
    S_LOAD_DATA = 3'd3,
    S_EXEC      = 3'd4,
    S_MD_WAIT   = 3'd5,
    S_HALT      = 3'd6,
    S_FAULT     = 3'd7
  } state_t;

  state_t          state_q, state_d, retire_state;
  logic [MD_W-1:0] md_cnt;
  logic [WD_W-1:0] wd_cnt;
  logic            is_load, is_store, is_md, misaligned, wd_trip;

  // LWL/LWR (34/38) and the byte ops never trap; halfword needs addr[0]=0, word needs addr=00.
  always_comb begin
    is_load    = opcode inside {[6'd32:6'd38]};
    is_store   = (opcode == 6'd40) || (opcode == 6'd41) || (opcode == 6'd43);
    is_md      = (opcode == 6'd0) && (function_code inside {[6'd24:6'd27]});
    misaligned = ALIGN_CHECK &&
                 ((((opcode == 6'd33) || (opcode == 6'd37) || (opcode == 6'd41)) && byte_addressing[0]) ||
                  (((opcode == 6'd35) || (opcode == 6'd43)) && (byte_addressing != 2'b00)));
    wd_trip    = (WAIT_MAX > 0) && (wd_cnt == WD_W'(WAIT_MAX));
  end

  always_comb begin
    state_d        = state_q;
    retire_state   = halt_req ? S_HALT : S_FETCH;
    read           = 1'b0;
    write          = 1'b0;
    byteenable     = 4'b1111;
    write_data_sel = 3'd0;
    ir_load        = 1'b0;
    exec_en        = 1'b0;
    pc_en          = 1'b0;
    load_wb        = 1'b0;
    md_busy        = 1'b0;
    active         = (state_q != S_HALT) && (state_q != S_FAULT);
    fault          = (state_q == S_FAULT);
    case (state_q)
      S_FETCH: begin
        read = 1'b1;
        if (wd_trip)           state_d = S_FAULT;
        else if (!waitrequest) state_d = S_IR_LATCH;
      end
      S_IR_LATCH: begin
        ir_load = 1'b1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        exec_en = 1'b1;
        if (is_load || is_store) begin
          state_d = misaligned ? S_FAULT : S_MEM;
        end else if (is_md) begin
          state_d = S_MD_WAIT;
        end else begin
          pc_en   = 1'b1;
          state_d = retire_state;
        end
      end
      S_MEM: begin
        if (is_store) begin
          write = 1'b1;
          case (opcode)
            6'd40: begin
              case (byte_addressing)
                2'd0:    begin byteenable = 4'b0001; write_data_sel = 3'd1; end
                2'd1:    begin byteenable = 4'b0010; write_data_sel = 3'd2; end
                2'd2:    begin byteenable = 4'b0100; write_data_sel = 3'd3; end
                default: begin byteenable = 4'b1000; write_data_sel = 3'd4; end
              endcase
            end
            6'd41: begin
              byteenable     = byte_addressing[1] ? 4'b1100 : 4'b0011;
              write_data_sel = byte_addressing[1] ? 3'd6 : 3'd5;
            end
            default: begin
              byteenable     = 4'b1111;
              write_data_sel = 3'd0;
            end
          endcase
        end else begin
          read = 1'b1;
        end
        if (wd_trip) begin
          state_d = S_FAULT;
        end else if (!waitrequest) begin
          if (is_store) begin
            pc_en   = 1'b1;
            state_d = retire_state;
          end else begin
            state_d = S_LOAD_DATA;
          end
        end
      end
      S_LOAD_DATA: begin
        load_wb = 1'b1;
        pc_en   = 1'b1;
        state_d = retire_state;
      end
      S_MD_WAIT: begin
        md_busy = 1'b1;
        if (md_cnt == '0) begin
          pc_en   = 1'b1;
          state_d = retire_state;
        end
      end
      default: state_d = state_q;
    endcase
    // Asynchronous reset must silence the bus immediately, even mid-transfer.
    if (!reset) begin
      read           = 1'b0;
      write          = 1'b0;
      byteenable     = 4'b1111;
      write_data_sel = 3'd0;
      ir_load        = 1'b0;
      exec_en        = 1'b0;
      pc_en          = 1'b0;
      load_wb        = 1'b0;
      md_busy        = 1'b0;
      active         = 1'b0;
      fault          = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      md_cnt <= '0;
    else if ((state_d == S_MD_WAIT) && (state_q != S_MD_WAIT))
      md_cnt <= MD_W'(MD_LAT - 1);
    else if ((state_q == S_MD_WAIT) && (md_cnt != '0))
      md_cnt <= md_cnt - MD_W'(1);
  end

  // Stall counter restarts on every state change and saturates instead of wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      wd_cnt <= '0;
    else if (state_d != state_q)
      wd_cnt <= '0;
    else if ((WAIT_MAX > 0) && (read || write) && waitrequest && (wd_cnt != '1))
      wd_cnt <= wd_cnt + WD_W'(1);
  end

  assign state = state_q;

endmodule
